// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: 32-iteration shift-add unsigned multiplier with HI/LO pair (MULTU/MADDU, MFHI/MFLO)
module multu_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nop,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             done
);
  localparam logic [5:0] MULTU     = 6'b011001;
  localparam logic [5:0] MADDU     = 6'b011100;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;
  localparam logic [5:0] MULTU_OUT = 6'b111111;
  localparam logic [5:0] MADDU_OUT = 6'b111110;
  localparam logic [5:0] NOP       = 6'b000000;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state;
  logic [WIDTH-1:0]     hi, lo, mplier;
  logic [2*WIDTH-1:0]   mcand, product, prod_next, sum_run, sum_done;
  logic [CW-1:0]        count;
  logic [5:0]           op_eff, op_prev, start_op, pend, pend_next;
  logic                 is_start, is_commit, keep;
  assign busy = state == RUN;
  always_comb begin
    op_eff    = nop ? NOP : op;
    is_start  = (op_eff == MULTU || op_eff == MADDU) && op_eff != op_prev;
    is_commit = op_eff == MULTU_OUT || op_eff == MADDU_OUT;
    keep      = is_commit || op_eff == start_op || op_eff == MFHI || op_eff == MFLO || op_eff == NOP;
    prod_next = product + (mplier[0] ? mcand : '0);
    pend_next = is_commit ? op_eff : pend;
    // commit kind is taken from the commit code, never from the start code
    sum_run   = pend_next == MADDU_OUT ? {hi, lo} + prod_next : prod_next;
    sum_done  = op_eff == MADDU_OUT ? {hi, lo} + product : product;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hi         <= '0;
      lo         <= '0;
      mcand      <= '0;
      mplier     <= '0;
      product    <= '0;
      count      <= '0;
      op_prev    <= NOP;
      start_op   <= NOP;
      pend       <= NOP;
      hilo_rdata <= '0;
      done       <= 1'b0;
    end else begin
      op_prev <= op_eff;
      done    <= 1'b0;
      if (op_eff == MFHI) hilo_rdata <= hi;
      else if (op_eff == MFLO) hilo_rdata <= lo;
      if ((state == IDLE || state == DONE) && is_start) begin
        state    <= RUN;
        start_op <= op_eff;
        mcand    <= {{WIDTH{1'b0}}, src_a};
        mplier   <= src_b;
        product  <= '0;
        count    <= '0;
        pend     <= NOP;
      end else begin
        case (state)
          RUN: begin
            if (!keep) begin
              state <= IDLE;
              pend  <= NOP;
            end else begin
              product <= prod_next;
              mcand   <= mcand << 1;
              mplier  <= mplier >> 1;
              count   <= count + 1'b1;
              pend    <= pend_next;
              if (count == LAST) begin
                // a commit seen during RUN lands on the final iteration edge
                if (pend_next != NOP) begin
                  {hi, lo} <= sum_run;
                  done     <= 1'b1;
                  state    <= IDLE;
                  pend     <= NOP;
                end else begin
                  state <= DONE;
                end
              end
            end
          end
          DONE: begin
            if (is_commit) begin
              {hi, lo} <= sum_done;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed checks of multiply, accumulate, early commit, abort, stall and reset
module tb_multu_hilo_unit;
  localparam logic [5:0] MULTU     = 6'b011001;
  localparam logic [5:0] MADDU     = 6'b011100;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;
  localparam logic [5:0] MULTU_OUT = 6'b111111;
  localparam logic [5:0] MADDU_OUT = 6'b111110;
  localparam logic [5:0] NOP       = 6'b000000;
  localparam logic [5:0] ADD       = 6'b100000;
  logic        clk = 1'b0, rst = 1'b1, nop = 1'b0;
  logic [5:0]  op = NOP;
  logic [31:0] src_a = '0, src_b = '0, hilo_rdata;
  logic        busy, done;
  int          total = 0, bad = 0;
  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .nop(nop), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_rdata(hilo_rdata), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [5:0] o);
    op = o;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [5:0] code, input logic [31:0] exp);
    step(code);
    chk(tag, 64'(hilo_rdata), 64'(exp));
    step(NOP);
  endtask
  task automatic mul(input string tag, input logic [5:0] code, input logic [31:0] a, input logic [31:0] b, input logic [5:0] commit);
    int nb;
    nb = 0;
    src_a = a;
    src_b = b;
    step(code);
    repeat (32) begin
      if (busy) nb++;
      step(NOP);
    end
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
    chk({tag, "_no_early_done"}, 64'(done), 64'd0);
    step(commit);
    chk({tag, "_done"}, 64'(done), 64'd1);
    step(NOP);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask
  initial begin
    int nd;
    step(NOP);
    step(NOP);
    chk("rst_rdata", 64'(hilo_rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step(NOP);
    // max operands
    mul("max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULTU_OUT);
    rd("max_hi", MFHI, 32'hFFFF_FFFE);
    rd("max_lo", MFLO, 32'h0000_0001);
    // accumulate
    mul("pre5", MULTU, 32'd5, 32'd1, MULTU_OUT);
    mul("acc", MADDU, 32'd3, 32'd4, MADDU_OUT);
    rd("acc_lo", MFLO, 32'h0000_0011);
    rd("acc_hi", MFHI, 32'h0000_0000);
    // wrap: FFFFFFFE_00000001 + 1_FFFFFFFE = all ones, then +1 wraps to zero
    mul("w1", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULTU_OUT);
    mul("w2", MADDU, 32'hFFFF_FFFF, 32'd2, MADDU_OUT);
    rd("w2_hi", MFHI, 32'hFFFF_FFFF);
    rd("w2_lo", MFLO, 32'hFFFF_FFFF);
    mul("w3", MADDU, 32'd1, 32'd1, MADDU_OUT);
    rd("wrap_hi", MFHI, 32'h0);
    rd("wrap_lo", MFLO, 32'h0);
    // early commit during RUN
    src_a = 32'd7;
    src_b = 32'd6;
    nd = 0;
    step(MULTU);
    for (int i = 1; i <= 32; i++) begin
      step(i == 20 ? MULTU_OUT : NOP);
      if (done) nd++;
    end
    chk("early_done", 64'(done), 64'd1);
    chk("early_busy", 64'(busy), 64'd0);
    repeat (3) begin
      step(NOP);
      if (done) nd++;
    end
    chk("early_single_done", 64'(nd), 64'd1);
    step(MADDU_OUT);
    chk("early_idle_ignores_commit", 64'(done), 64'd0);
    step(NOP);
    rd("early_lo", MFLO, 32'd42);
    rd("early_hi", MFHI, 32'd0);
    // abort, with a read during RUN
    src_a = 32'd9;
    src_b = 32'd9;
    step(MULTU);
    for (int i = 1; i <= 9; i++) begin
      step(i == 5 ? MFLO : NOP);
      if (i == 5) chk("run_read_old_lo", 64'(hilo_rdata), 64'd42);
    end
    chk("abort_pre_busy", 64'(busy), 64'd1);
    step(ADD);
    chk("abort_busy", 64'(busy), 64'd0);
    nd = 0;
    repeat (40) begin
      step(NOP);
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    rd("abort_lo", MFLO, 32'd42);
    // stall suppresses start
    nop = 1'b1;
    step(MULTU);
    chk("nop_busy1", 64'(busy), 64'd0);
    step(MULTU);
    chk("nop_busy2", 64'(busy), 64'd0);
    step(NOP);
    nop = 1'b0;
    step(NOP);
    chk("nop_busy3", 64'(busy), 64'd0);
    // reset mid-RUN
    step(MULTU);
    repeat (14) step(NOP);
    chk("rst_run_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step(NOP);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_rdata", 64'(hilo_rdata), 64'd0);
    rst = 1'b0;
    rd("midrst_lo", MFLO, 32'd0);
    mul("post", MULTU, 32'd2, 32'd3, MULTU_OUT);
    rd("post_lo", MFLO, 32'd6);
    // commit kind follows the commit code: MADDU start with MULTU_out overwrites
    mul("kind", MADDU, 32'd4, 32'd5, MULTU_OUT);
    rd("kind_lo", MFLO, 32'd20);
    rd("kind_hi", MFHI, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
